edge_capture: RTL and testbench
===============================

EDGE_CAPTURE -- requirements
Module: edge_capture

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel (2..4).
REQ-003 Parameter CNT_W, default 8: width of each per-channel event counter (2..16).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; asserts immediately and is released synchronously to clk.
REQ-006 signal  input  WIDTH  asynchronous channel inputs.
REQ-007 mode  input  2  detect mode for all channels: 00 rising, 01 falling, 10 both, 11 disabled.
REQ-008 clr  input  WIDTH  per-channel synchronous clear of sticky flag and counter.
REQ-009 irq_en  input  WIDTH  per-channel interrupt enable.
REQ-010 cnt_sel  input  max(1,$clog2(WIDTH))  selects the channel driven onto cnt_out.
REQ-011 pulse  output  WIDTH  one-cycle registered event strobe per channel.
REQ-012 sticky  output  WIDTH  per-channel event-seen flag.
REQ-013 cnt_out  output  CNT_W  counter value of channel cnt_sel (combinational mux of registered counters).
REQ-014 irq  output  1  registered OR of (sticky & irq_en).

Function
REQ-015 Each channel SHALL pass through SYNC_STAGES flops, then one history flop; detection compares the last sync stage with the history flop.
REQ-016 pulse[i] SHALL rise on the (SYNC_STAGES+1)th clock edge, counting the first edge that samples the new input level as edge 1, and SHALL be high for exactly one cycle.
REQ-017 Rising mode: pulse on 0->1 only; falling: 1->0 only; both: any change; disabled: pulse stays 0, history keeps tracking.
REQ-018 mode changes SHALL take effect at the next edge and SHALL NOT by themselves generate a pulse.
REQ-019 Input toggles shorter than one clock period are not guaranteed to be detected; toggles stable for at least 2 cycles SHALL each be detected.
REQ-020 sticky[i] SHALL set on pulse[i]; clr[i] clears it; pulse and clr in the same cycle leave sticky set.
REQ-021 Counter[i] SHALL increment on pulse[i] and saturate at 2^CNT_W-1 (no wrap).
REQ-022 clr[i] SHALL zero counter[i]; clr and pulse in the same cycle SHALL load 1.
REQ-023 Out-of-range cnt_sel (>= WIDTH) SHALL yield cnt_out = 0.
REQ-024 irq SHALL follow sticky & irq_en with one cycle latency.
REQ-025 Warm-up: after reset release, a down-counter SHALL suppress all pulses for SYNC_STAGES+1 cycles while the history flop loads the real input level, so a level high at reset release produces no pulse.

Reset
REQ-026 While rst is low: sync flops, history flops, pulse, sticky, counters, irq all 0; warm-up counter loaded to SYNC_STAGES+1.
REQ-027 Reset asserted mid-operation SHALL clear all state within the same cycle (asynchronous), discarding in-flight edges.

Structure
REQ-028 Mode encodings (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_OFF) SHALL live in shared package edge_pkg.
REQ-029 Per-bit synchroniser SHALL be sub-module sync_chain (parameter STAGES), instantiated WIDTH times; detection, counters and warm-up stay in edge_capture.
REQ-030 No latches; all outputs except cnt_out driven directly from flops.

Verification (WIDTH=4, SYNC_STAGES=2, CNT_W=4, clk period 10)
REQ-031 Reset release with signal=4'b0001, mode=00 -> no pulse during or after warm-up; sticky=0, cnt_out(sel 0)=0.
REQ-032 mode=00, signal[1] 0->1 sampled at edge k -> pulse[1] high exactly after edge k+2 for one cycle; sticky[1]=1; cnt_sel=1 gives cnt_out=1.
REQ-033 mode=10, signal[2] toggled 5 times, 3 cycles apart -> 5 pulses, cnt_out=5; mode=01, same stimulus -> only falling edges counted.
REQ-034 20 rising edges on channel 3 -> cnt_out saturates at 15; clr[3] coincident with a pulse -> cnt_out=1, sticky[3]=1.
REQ-035 irq_en=4'b0100 with event on channel 0 only -> irq stays 0; event on channel 2 -> irq=1 one cycle after sticky[2]; clr[2] -> irq=0 one cycle later.
REQ-036 rst pulled low mid-pulse -> pulse, sticky, counters, irq 0 immediately; after release, warm-up repeats with no spurious pulse.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared detect-mode encodings and the edge-qualification helper for edge_capture.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  // True when the transition prev -> cur is one the selected mode reports.
  function automatic logic edge_hit(input logic [1:0] mode, input logic cur, input logic prev);
    logic hit;
    case (mode_e'(mode))
      MODE_RISE: hit = cur & ~prev;
      MODE_FALL: hit = ~cur & prev;
      MODE_BOTH: hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_capture_sync.sv
// Single-bit multi-flop synchroniser for one asynchronous channel input.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/edge_capture.sv
// Multi-channel edge detector with per-channel sticky flags, saturating event
// counters, a selectable counter readout and a masked interrupt.
module edge_capture
  import edge_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  localparam int SEL_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] signal,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] clr,
  input  logic [WIDTH-1:0] irq_en,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [WIDTH-1:0] pulse,
  output logic [WIDTH-1:0] sticky,
  output logic [CNT_W-1:0] cnt_out,
  output logic             irq
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [WIDTH-1:0]  w_sync;
  logic [WIDTH-1:0]  w_det;
  logic              w_armed;
  logic [CNT_W-1:0]  w_cnt [WIDTH];

  logic [WARM_W-1:0] r_warm;
  logic [WIDTH-1:0]  r_hist;
  logic [WIDTH-1:0]  r_pulse;
  logic [WIDTH-1:0]  r_sticky;
  logic              r_irq;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;

      sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (signal[gi]),
        .o_q (w_sync[gi])
      );

      assign w_det[gi] = w_armed & edge_hit(mode, w_sync[gi], r_hist[gi]);

      // A clear that coincides with a strobe keeps that event: load 1, not 0.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt <= '0;
        end else if (clr[gi]) begin
          r_cnt <= {{(CNT_W-1){1'b0}}, r_pulse[gi]};
        end else if (r_pulse[gi] && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  assign w_armed = (r_warm == '0);

  // Warm-up gives the history flops time to load the real input level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_warm <= WARM_INIT;
    end else if (!w_armed) begin
      r_warm <= r_warm - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist   <= '0;
      r_pulse  <= '0;
      r_sticky <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_hist   <= w_sync;
      r_pulse  <= w_det;
      r_sticky <= (r_sticky & ~clr) | r_pulse;
      r_irq    <= |(r_sticky & irq_en);
    end
  end

  always_comb begin
    cnt_out = '0;
    if (int'(cnt_sel) < WIDTH) begin
      cnt_out = w_cnt[cnt_sel];
    end
  end

  assign pulse  = r_pulse;
  assign sticky = r_sticky;
  assign irq    = r_irq;

endmodule

// File: tb/tb_edge_capture.sv
// Scoreboard bench for edge_capture: expected strobes are queued when an input
// edge is driven and compared when their due cycle arrives.
module tb_edge_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] signal = '0;
  logic [1:0] mode = '0;
  logic [3:0] clr = '0;
  logic [3:0] irq_en = '0;
  logic [1:0] cnt_sel = '0;
  logic [3:0] pulse;
  logic [3:0] sticky;
  logic [3:0] cnt_out;
  logic       irq;

  typedef struct {
    int         due;
    logic [3:0] mask;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  edge_capture #(.WIDTH(4), .SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .signal  (signal),
    .mode    (mode),
    .clr     (clr),
    .irq_en  (irq_en),
    .cnt_sel (cnt_sel),
    .pulse   (pulse),
    .sticky  (sticky),
    .cnt_out (cnt_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic expect_pulse(input logic [1:0] m, input logic prev, input logic cur);
    case (m)
      2'b00:   return !prev && cur;
      2'b01:   return prev && !cur;
      2'b10:   return prev != cur;
      default: return 1'b0;
    endcase
  endfunction

  // Sampled at edge cyc+1, strobe visible after edge cyc+3 (two sync stages).
  task automatic drive(input int ch, input logic v);
    logic prev;
    exp_t e;
    prev = signal[ch];
    signal[ch] = v;
    if (expect_pulse(mode, prev, v)) begin
      e.due  = cyc + 3;
      e.mask = 4'b0001 << ch;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      check_val($sformatf("pulse_due%0d", sb[0].due), {28'd0, pulse}, {28'd0, sb[0].mask});
      void'(sb.pop_front());
    end else if (pulse !== 4'b0000) begin
      check_val("pulse_spurious", {28'd0, pulse}, 32'd0);
    end
  end

  initial begin
    // Reset with channel 0 already high: warm-up must hide it.
    signal = 4'b0001;
    tick(3);
    check_val("rst_pulse", {28'd0, pulse}, 32'd0);
    check_val("rst_sticky", {28'd0, sticky}, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    check_val("rst_cnt", {28'd0, cnt_out}, 32'd0);
    rst = 1'b1;
    tick(8);
    check_val("warm_sticky", {28'd0, sticky}, 32'd0);
    check_val("warm_cnt0", {28'd0, cnt_out}, 32'd0);

    // Single rising edge on channel 1.
    drive(1, 1'b1);
    tick(5);
    check_val("ch1_sticky", {31'd0, sticky[1]}, 32'd1);
    cnt_sel = 2'd1;
    #1;
    check_val("ch1_cnt", {28'd0, cnt_out}, 32'd1);
    check_val("ch1_irq_masked", {31'd0, irq}, 32'd0);
    drive(1, 1'b0);
    tick(5);
    check_val("ch1_fall_ignored", {28'd0, cnt_out}, 32'd1);

    // Both-edge mode, then falling-only, on channel 2.
    clr = 4'b0100;
    tick(1);
    clr = 4'b0000;
    mode = 2'b10;
    for (int k = 0; k < 5; k++) begin
      drive(2, ~signal[2]);
      tick(3);
    end
    tick(4);
    cnt_sel = 2'd2;
    #1;
    check_val("both_cnt", {28'd0, cnt_out}, 32'd5);
    check_val("both_sticky", {31'd0, sticky[2]}, 32'd1);
    clr = 4'b0100;
    tick(1);
    clr = 4'b0000;
    check_val("clr_cnt", {28'd0, cnt_out}, 32'd0);
    mode = 2'b01;
    for (int k = 0; k < 5; k++) begin
      drive(2, ~signal[2]);
      tick(3);
    end
    tick(4);
    check_val("fall_cnt", {28'd0, cnt_out}, 32'd3);

    // Saturation, then clear coincident with a strobe.
    mode = 2'b00;
    clr = 4'b1000;
    tick(1);
    clr = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      drive(3, 1'b1);
      tick(3);
      drive(3, 1'b0);
      tick(3);
    end
    tick(4);
    cnt_sel = 2'd3;
    #1;
    check_val("cnt_sat", {28'd0, cnt_out}, 32'd15);
    drive(3, 1'b1);
    tick(3);
    clr = 4'b1000;
    tick(1);
    clr = 4'b0000;
    check_val("clr_pulse_cnt", {28'd0, cnt_out}, 32'd1);
    check_val("clr_pulse_sticky", {31'd0, sticky[3]}, 32'd1);

    // Interrupt masking and latency.
    clr = 4'b1111;
    tick(1);
    clr = 4'b0000;
    irq_en = 4'b0100;
    drive(0, 1'b0);
    tick(3);
    drive(0, 1'b1);
    tick(6);
    check_val("ch0_sticky", {31'd0, sticky[0]}, 32'd1);
    check_val("ch0_irq_masked", {31'd0, irq}, 32'd0);
    drive(2, 1'b1);
    tick(4);
    check_val("ch2_sticky", {31'd0, sticky[2]}, 32'd1);
    check_val("irq_lag", {31'd0, irq}, 32'd0);
    tick(1);
    check_val("irq_set", {31'd0, irq}, 32'd1);
    clr = 4'b0100;
    tick(1);
    clr = 4'b0000;
    check_val("clr2_sticky", {31'd0, sticky[2]}, 32'd0);
    check_val("irq_hold", {31'd0, irq}, 32'd1);
    tick(1);
    check_val("irq_clr", {31'd0, irq}, 32'd0);

    // Asynchronous reset in the middle of a strobe.
    irq_en = 4'b1111;
    drive(1, 1'b1);
    tick(3);
    check_val("pulse_pre_rst", {28'd0, pulse}, 32'd2);
    check_val("irq_pre_rst", {31'd0, irq}, 32'd1);
    sb.delete();
    rst = 1'b0;
    #1;
    check_val("arst_pulse", {28'd0, pulse}, 32'd0);
    check_val("arst_sticky", {28'd0, sticky}, 32'd0);
    check_val("arst_irq", {31'd0, irq}, 32'd0);
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      check_val($sformatf("arst_cnt%0d", s), {28'd0, cnt_out}, 32'd0);
    end
    tick(3);
    rst = 1'b1;
    tick(10);
    check_val("rewarm_sticky", {28'd0, sticky}, 32'd0);
    mode = 2'b10;
    drive(2, 1'b0);
    tick(6);
    cnt_sel = 2'd2;
    #1;
    check_val("post_rst_cnt", {28'd0, cnt_out}, 32'd1);
    check_val("post_rst_sticky", {28'd0, sticky}, 32'd4);
    tick(2);
    check_val("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
